// File: rtl/dcache.sv
// Direct-mapped, write-through / write-allocate data cache: 16 one-word lines.
// Read hits are answered combinationally; misses and all writes go to memory.
`default_nettype none

module dcache (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;

  state_t      state, state_n;
  logic [29:0] lat_addr;
  logic [31:0] lat_data;
  logic [15:0] valid;
  logic [25:0] tag_arr  [16];
  logic [31:0] data_arr [16];

  logic [3:0]  req_idx;
  logic [3:0]  lat_idx;
  logic        req_hit;
  logic        latch_req;
  logic        line_we;
  logic [31:0] line_wdata;
  logic        unused_addr_bits;

  assign req_idx          = dmemaddr[5:2];
  assign lat_idx          = lat_addr[3:0];
  assign req_hit          = valid[req_idx] && (tag_arr[req_idx] == dmemaddr[31:6]);
  assign unused_addr_bits = ^dmemaddr[1:0];

  always_comb begin
    state_n    = state;
    dhit       = 1'b0;
    dmemload   = 32'd0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = 32'd0;
    dstore     = 32'd0;
    latch_req  = 1'b0;
    line_we    = 1'b0;
    line_wdata = lat_data;
    case (state)
      IDLE: begin
        if (dmemWEN) begin
          state_n   = WRITE;
          latch_req = 1'b1;
        end else if (dmemREN) begin
          if (req_hit) begin
            dhit     = 1'b1;
            dmemload = data_arr[req_idx];
          end else begin
            state_n   = FILL;
            latch_req = 1'b1;
          end
        end
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {lat_addr, 2'b00};
        if (!dwait) begin
          state_n    = IDLE;
          line_we    = 1'b1;
          line_wdata = dload;
        end
      end
      WRITE: begin
        dWEN   = 1'b1;
        daddr  = {lat_addr, 2'b00};
        dstore = lat_data;
        if (!dwait) begin
          state_n = IDLE;
          line_we = 1'b1;
          // A withdrawn write still lands in memory and the line, but is not acknowledged.
          dhit    = dmemWEN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      lat_addr <= 30'd0;
      lat_data <= 32'd0;
      valid    <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        tag_arr[i]  <= 26'd0;
        data_arr[i] <= 32'd0;
      end
    end else begin
      state <= state_n;
      if (latch_req) begin
        lat_addr <= dmemaddr[31:2];
        lat_data <= dmemstore;
      end
      if (line_we) begin
        valid[lat_idx]    <= 1'b1;
        tag_arr[lat_idx]  <= lat_addr[29:4];
        data_arr[lat_idx] <= line_wdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache.sv
// Randomized self-checking bench for dcache against a transaction-level cache/memory model.
`default_nettype none

module tb_dcache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic        dwait;
  logic [31:0] dload;

  dcache dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cache contents and backing memory
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem     [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0] ^ 16'h5A5A, ~wa[15:0]};
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[31:6]);
  endfunction

  function automatic void m_install(input logic [31:0] a, input logic [31:0] d);
    m_valid[a[5:2]] = 1'b1;
    m_tag[a[5:2]]   = a[31:6];
    m_data[a[5:2]]  = d;
  endfunction

  task automatic idle_cycle();
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0; dwait = 1'($urandom); dload = $urandom;
    #1;
    chk("idle_dhit", {31'd0, dhit}, 32'd0);
    chk("idle_dren", {31'd0, dREN}, 32'd0);
    chk("idle_dwen", {31'd0, dWEN}, 32'd0);
    chk("idle_daddr", daddr, 32'd0);
    chk("idle_dstore", dstore, 32'd0);
    chk("idle_dmemload", dmemload, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int waits, input bit withdraw);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    @(negedge CLK);
    dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = a; dwait = 1'($urandom); dload = $urandom;
    #1;
    if (m_hit(a)) begin
      chk("rd_hit", {31'd0, dhit}, 32'd1);
      chk("rd_hit_data", dmemload, m_data[a[5:2]]);
      chk("rd_hit_dren", {31'd0, dREN}, 32'd0);
    end else begin
      chk("rd_miss_dhit", {31'd0, dhit}, 32'd0);
      chk("rd_miss_dren", {31'd0, dREN}, 32'd0);
      for (int k = 0; k <= waits; k++) begin
        @(negedge CLK);
        dwait = (k < waits);
        dload = dwait ? $urandom : mem_rd(wa);
        if (withdraw && k == 0) dmemREN = 1'b0;
        #1;
        chk("fill_dren", {31'd0, dREN}, 32'd1);
        chk("fill_dwen", {31'd0, dWEN}, 32'd0);
        chk("fill_daddr", daddr, wa);
        chk("fill_dhit", {31'd0, dhit}, 32'd0);
      end
      m_install(a, mem_rd(wa));
      if (!withdraw) begin
        @(negedge CLK);
        dwait = 1'($urandom); dload = $urandom;
        #1;
        chk("refill_dhit", {31'd0, dhit}, 32'd1);
        chk("refill_data", dmemload, mem_rd(wa));
        chk("refill_dren", {31'd0, dREN}, 32'd0);
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int waits,
                          input bit withdraw, input bit with_ren);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    @(negedge CLK);
    dmemWEN = 1'b1; dmemREN = with_ren; dmemaddr = a; dmemstore = d;
    dwait = 1'($urandom); dload = $urandom;
    #1;
    chk("wr_accept_dhit", {31'd0, dhit}, 32'd0);
    chk("wr_accept_dwen", {31'd0, dWEN}, 32'd0);
    chk("wr_accept_dren", {31'd0, dREN}, 32'd0);
    for (int k = 0; k <= waits; k++) begin
      @(negedge CLK);
      dwait = (k < waits);
      dload = $urandom;
      if (k > 0) begin
        dmemaddr  = withdraw ? $urandom : a;
        dmemstore = $urandom;
      end
      if (withdraw && k == 0) begin dmemWEN = 1'b0; dmemREN = 1'b0; end
      #1;
      chk("wr_dwen", {31'd0, dWEN}, 32'd1);
      chk("wr_dren", {31'd0, dREN}, 32'd0);
      chk("wr_daddr", daddr, wa);
      chk("wr_dstore", dstore, d);
      chk("wr_dhit", {31'd0, dhit}, {31'd0, (k == waits) && !withdraw});
    end
    mem[wa] = d;
    m_install(a, d);
  endtask

  initial begin
    logic [31:0] a;
    int op;
    nRST = 1'b0;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = 32'd0; dmemstore = 32'd0;
    dwait = 1'b1; dload = 32'd0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;

    // Reset state, even with a request pending
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = 32'h40;
    #1;
    chk("rst_dhit", {31'd0, dhit}, 32'd0);
    chk("rst_dren", {31'd0, dREN}, 32'd0);
    chk("rst_dwen", {31'd0, dWEN}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    idle_cycle();

    // Cold read, then repeat hit
    mem[32'h40] = 32'hDEAD_BEEF;
    do_read(32'h40, 3, 1'b0);
    do_read(32'h40, 0, 1'b0);
    // Write with waits, then read back
    do_write(32'h80, 32'h1234_5678, 2, 1'b0, 1'b0);
    do_read(32'h80, 0, 1'b0);
    // Conflict on index 0
    do_read(32'h440, 1, 1'b0);
    do_read(32'h40, 0, 1'b0);
    // Simultaneous requests: write wins
    do_write(32'h100, 32'hCAFE_F00D, 1, 1'b0, 1'b1);
    do_read(32'h100, 0, 1'b0);
    // Withdrawn write and withdrawn fill still update the line
    do_write(32'h4C0, 32'h0BAD_F00D, 1, 1'b1, 1'b0);
    do_read(32'h4C0, 0, 1'b0);
    do_read(32'h3C4, 2, 1'b1);
    do_read(32'h3C4, 0, 1'b0);
    idle_cycle();

    // Reset in the middle of a fill
    @(negedge CLK);
    dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h2F8; dwait = 1'b1;
    repeat (2) @(negedge CLK);
    #2;
    nRST = 1'b0; dmemREN = 1'b0;
    #1;
    chk("midfill_rst_dren", {31'd0, dREN}, 32'd0);
    chk("midfill_rst_daddr", daddr, 32'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    do_read(32'h2F8, 1, 1'b0);

    // Randomized mix over a small address pool to provoke hits and conflicts
    for (int n = 0; n < 400; n++) begin
      a = ({30'd0, 2'($urandom)} << 6) | ({28'd0, 4'($urandom)} << 2) | {30'd0, 2'($urandom)};
      if ($urandom_range(0, 3) == 0) a[28] = 1'b1;
      op = $urandom_range(0, 9);
      if (op <= 4)      do_read(a, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      else if (op <= 7) do_write(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 7) == 0, 1'b0);
      else if (op == 8) do_write(a, $urandom, $urandom_range(0, 2), 1'b0, 1'b1);
      else              idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  asynchronous, active-low reset.
REQ-003 dmemREN  input  1  pipeline data-read request; held until dhit or withdrawn.
REQ-004 dmemWEN  input  1  pipeline data-write request; held until dhit or withdrawn.
REQ-005 dmemaddr  input  32  byte address (word_t); bits [1:0] ignored.
REQ-006 dmemstore  input  32  write data.
REQ-007 dhit  output  1  request serviced this cycle; single-cycle pulse for each write.
REQ-008 dmemload  output  32  read data; valid only while dhit=1 for a read.
REQ-009 dREN  output  1  memory-side read request.
REQ-010 dWEN  output  1  memory-side write request.
REQ-011 daddr  output  32  memory-side word address, with bits [1:0]=0.
REQ-012 dstore  output  32  memory-side write data.
REQ-013 dwait  input  1  memory busy; a transfer completes in the first cycle dwait=0 while dREN or dWEN is asserted.
REQ-014 dload  input  32  memory-side read data; valid when dwait=0.

Function
REQ-015 Organisation: direct-mapped; 16 one-word lines; index = dmemaddr[5:2]; tag = dmemaddr[31:6]; one valid bit per line.
REQ-016 Policy: write-through, write-allocate; no dirty state; no flush required.
REQ-017 FSM states: IDLE, FILL, WRITE.
REQ-018 IDLE, dmemWEN=1: go to WRITE; dhit=0 this cycle; dmemWEN has priority when both requests are high.
REQ-019 IDLE, dmemREN=1, dmemWEN=0, valid and tag match: dhit=1 and dmemload=line data, combinationally in the same cycle; remain in IDLE.
REQ-020 IDLE, dmemREN=1, dmemWEN=0, miss: go to FILL; dhit=0.
REQ-021 FILL: dREN=1, daddr={dmemaddr[31:2],2'b00} latched on entry; while dwait=1, stay.
REQ-022 FILL, dwait=0: write dload into the line, set tag and valid, return to IDLE; dhit=0; the hit is reported in IDLE on the next cycle.
REQ-023 WRITE: dWEN=1, with daddr and dstore latched on entry; while dwait=1, stay.
REQ-024 WRITE, dwait=0: write dstore into the line, set tag and valid, dhit=1 for exactly this cycle, go to IDLE.
REQ-025 Outside FILL and WRITE, dREN=0, dWEN=0, daddr=0 and dstore=0.
REQ-026 Withdrawal: if the request drops during FILL or WRITE, the memory transfer still completes and the line is still updated; dhit is suppressed when dmemWEN is low in the completing WRITE cycle.
REQ-027 dREN and dWEN are never asserted together; every memory transfer is held stable until dwait=0.
REQ-028 Back-to-back: a new request seen in IDLE the cycle after completion is accepted without an extra idle cycle.
REQ-029 A write hitting a valid line with a different tag overwrites the line (replacement).
REQ-030 Combinational outputs carry no latches; all state elements are reset asynchronously.

Reset
REQ-031 On nRST=0: FSM=IDLE; all valid bits=0; latched address and data=0; dhit=0, dmemload=0, dREN=0, dWEN=0, daddr=0, dstore=0.
REQ-032 Reset during FILL or WRITE aborts the transfer immediately, with no line update.
REQ-033 Tag and data arrays need not be reset, because valid=0 masks them.

Verification
REQ-034 Cold read at 0x0000_0040; memory returns 0xDEAD_BEEF after 3 dwait cycles -> dREN=1 for 4 cycles, daddr=0x40, dhit on the following cycle with dmemload=0xDEAD_BEEF.
REQ-035 Repeat read of 0x40 -> dhit=1 in the same cycle, dREN stays 0.
REQ-036 Write 0x1234_5678 to 0x80 with dwait=1 for 2 cycles -> dWEN=1 for 3 cycles, dhit pulses once; a later read of 0x80 hits with 0x1234_5678.
REQ-037 Conflict: read 0x40, then read 0x440 (same index, different tag) -> second read misses and refills; a re-read of 0x40 misses again.
REQ-038 Both dmemREN and dmemWEN high at 0x100 -> write performed, no dREN issued.
REQ-039 nRST pulsed mid-FILL -> dREN drops asynchronously, and a subsequent read of the same address misses.
